// File: rtl/pong_ball_engine_if.sv
// ---------------------------------------------------------------------------
// pong_ball_engine_if
//
// Bundle between the pong ball engine and its neighbours.
//   master : frame tick, start level and paddle positions in;
//            ball position, motion, score and status back.
//   slave  : the ball engine itself.
//
// Signals:
//   refresh_tick  one-clk pulse per frame
//   start         level, only meaningful in IDLE / GAME_OVER
//   paddle1_y     left paddle top y
//   paddle2_y     right paddle top y
//   ball_x/y      ball top-left corner
//   dir_x/dir_y   1 = moving right / down
//   speed         pixels per tick on each axis
//   score_p1/p2   player scores
//   winner        00 none, 01 P1, 10 P2
//   state         IDLE=0 SERVE=1 PLAY=2 POINT=3 GAME_OVER=4
//   hit_pulse     one-clk pulse on a paddle hit
//   score_pulse   one-clk pulse on a point
// ---------------------------------------------------------------------------
interface pong_ball_engine_if;
  logic       refresh_tick;
  logic       start;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic [3:0] speed;
  logic [5:0] score_p1;
  logic [5:0] score_p2;
  logic [1:0] winner;
  logic [2:0] state;
  logic       hit_pulse;
  logic       score_pulse;

  modport master (
    output refresh_tick, start, paddle1_y, paddle2_y,
    input  ball_x, ball_y, dir_x, dir_y, speed, score_p1, score_p2,
           winner, state, hit_pulse, score_pulse
  );

  modport slave (
    input  refresh_tick, start, paddle1_y, paddle2_y,
    output ball_x, ball_y, dir_x, dir_y, speed, score_p1, score_p2,
           winner, state, hit_pulse, score_pulse
  );
endinterface

// File: rtl/pong_ball_engine.sv
// ---------------------------------------------------------------------------
// pong_ball_engine
//
// Ball motion, paddle collision, scoring and match sequencing for pong.
// Every state change is gated by bus.refresh_tick (one per frame); the
// hit/score pulses are the only outputs that move on other clocks (they
// fall back to 0 one clk after being raised).
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    pong_ball_engine_if.slave (tick, start, paddles in; ball state,
//          scores, status and pulses out)
//
// Optional feature:
//   SPIN_EN  when defined, a paddle hit steers dir_y by the contact zone
//            (ball centre in top third -> up, bottom third -> down, middle
//            third -> unchanged). Undefined: hits never touch dir_y.
//
// All geometry is evaluated in 12-bit unsigned arithmetic, and every
// subtraction that could go below zero is rewritten as a comparison, so no
// boundary test can wrap.
// ---------------------------------------------------------------------------
module pong_ball_engine #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 72,
  parameter int P1_X           = 32,
  parameter int P2_X           = 600,
  parameter int SPEED_INIT     = 2,
  parameter int SPEED_MAX      = 6,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SERVE_DELAY    = 60,
  parameter int WIN_SCORE      = 11
) (
  input  logic                clk,
  input  logic                reset,
  pong_ball_engine_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  typedef logic [11:0] w_t;

  localparam int HW = $clog2(HITS_PER_LEVEL + 1);
  localparam int SW = $clog2(SERVE_DELAY + 1);

  localparam w_t BS       = w_t'(BALL_SIZE);
  localparam w_t HR       = w_t'(H_RES);
  localparam w_t VR       = w_t'(V_RES);
  localparam w_t PH       = w_t'(PADDLE_H);
  localparam w_t P1_LEFT  = w_t'(P1_X);
  localparam w_t P1_RIGHT = w_t'(P1_X + PADDLE_W);
  localparam w_t P2_LEFT  = w_t'(P2_X);
  localparam w_t P2_RIGHT = w_t'(P2_X + PADDLE_W);

  localparam logic [9:0] X_CENTRE   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CENTRE   = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_BOTTOM   = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] X_AFTER_P1 = 10'(P1_X + PADDLE_W + 1);
  localparam logic [9:0] X_AFTER_P2 = 10'(P2_X - BALL_SIZE);
  localparam logic [3:0] SPD_INIT   = 4'(SPEED_INIT);
  localparam logic [3:0] SPD_MAX    = 4'(SPEED_MAX);
  localparam logic [5:0] WIN        = 6'(WIN_SCORE);

  // Registered state and outputs
  state_t          state_q;
  logic [9:0]      ball_x_q;
  logic [9:0]      ball_y_q;
  logic            dir_x_q;
  logic            dir_y_q;
  logic [3:0]      speed_q;
  logic [5:0]      score_p1_q;
  logic [5:0]      score_p2_q;
  logic [1:0]      winner_q;
  logic            hit_pulse_q;
  logic            score_pulse_q;
  logic [HW-1:0]   hit_cnt_q;
  logic [SW-1:0]   serve_cnt_q;
  logic            p1_scored_q;   // who won the point now being resolved

  // Widened views of the current position, speed and paddles
  w_t bx, by, spd, p1y, p2y;
  assign bx  = {2'b00, ball_x_q};
  assign by  = {2'b00, ball_y_q};
  assign spd = {8'h00, speed_q};
  assign p1y = {2'b00, bus.paddle1_y};
  assign p2y = {2'b00, bus.paddle2_y};

  // Next-position candidates for one PLAY tick
  logic [9:0] x_next, y_next;
  logic       dy_next, dy_hit;
  logic       hit_p1, hit_p2, miss_left, miss_right;

  always_comb begin
    // Vertical: clamp to the wall and reflect rather than overshoot.
    y_next  = ball_y_q;
    dy_next = dir_y_q;
    if (!dir_y_q) begin
      if (by < spd) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next  = ball_y_q - {6'b0, speed_q};
      end
    end else if (by + BS + spd > VR) begin
      y_next  = Y_BOTTOM;
      dy_next = 1'b0;
    end else begin
      y_next  = ball_y_q + {6'b0, speed_q};
    end

    // Paddle face crossed this tick and vertical overlap with the paddle.
    hit_p1 = !dir_x_q && (bx >= P1_LEFT) && (bx <= P1_RIGHT + spd) &&
             (by + BS > p1y) && (by < p1y + PH);
    hit_p2 =  dir_x_q && (bx + BS <= P2_RIGHT) && (bx + BS + spd >= P2_LEFT) &&
             (by + BS > p2y) && (by < p2y + PH);

    miss_left  = !dir_x_q && (bx < spd);
    miss_right =  dir_x_q && (bx + BS + spd > HR);

    x_next = dir_x_q ? ball_x_q + {6'b0, speed_q} : ball_x_q - {6'b0, speed_q};
  end

`ifdef SPIN_EN
  localparam w_t HALF_BALL = w_t'(BALL_SIZE / 2);
  localparam w_t THIRD     = w_t'(PADDLE_H / 3);
  localparam w_t TWO_THIRD = w_t'((2 * PADDLE_H) / 3);

  w_t pad_top, ball_ctr;

  always_comb begin
    pad_top  = hit_p1 ? p1y : p2y;
    ball_ctr = by + HALF_BALL;
    dy_hit   = dy_next;
    if (ball_ctr < pad_top + THIRD) begin
      dy_hit = 1'b0;
    end else if (ball_ctr >= pad_top + TWO_THIRD) begin
      dy_hit = 1'b1;
    end
  end
`else
  assign dy_hit = dy_next;
`endif

  // NOTE: the reset branch is asynchronous (in the sensitivity list) and
  // every state element gets a reset value; nothing here is a memory array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ball_x_q      <= X_CENTRE;
      ball_y_q      <= Y_CENTRE;
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b1;
      speed_q       <= SPD_INIT;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      winner_q      <= 2'b00;
      hit_pulse_q   <= 1'b0;
      score_pulse_q <= 1'b0;
      hit_cnt_q     <= '0;
      serve_cnt_q   <= '0;
      p1_scored_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking default followed by a later override in the same
      // block; the last assignment wins, so pulses are high for one clk only.
      hit_pulse_q   <= 1'b0;
      score_pulse_q <= 1'b0;

      if (bus.refresh_tick) begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q     <= SERVE;
              serve_cnt_q <= '0;
              speed_q     <= SPD_INIT;
              hit_cnt_q   <= '0;
            end
          end

          SERVE: begin
            if (serve_cnt_q == SW'(SERVE_DELAY - 1)) begin
              state_q <= PLAY;
            end else begin
              serve_cnt_q <= serve_cnt_q + SW'(1);
            end
          end

          PLAY: begin
            if (hit_p1 || hit_p2) begin
              ball_x_q    <= hit_p1 ? X_AFTER_P1 : X_AFTER_P2;
              dir_x_q     <= hit_p1;
              ball_y_q    <= y_next;
              dir_y_q     <= dy_hit;
              hit_pulse_q <= 1'b1;
              if (hit_cnt_q == HW'(HITS_PER_LEVEL - 1)) begin
                hit_cnt_q <= '0;
                if (speed_q < SPD_MAX) speed_q <= speed_q + 4'd1;
              end else begin
                hit_cnt_q <= hit_cnt_q + HW'(1);
              end
            end else if (miss_left || miss_right) begin
              // Point: this tick's wall bounce is dropped, ball re-centred.
              ball_x_q      <= X_CENTRE;
              ball_y_q      <= Y_CENTRE;
              p1_scored_q   <= miss_right;
              if (miss_right) score_p1_q <= score_p1_q + 6'd1;
              else            score_p2_q <= score_p2_q + 6'd1;
              score_pulse_q <= 1'b1;
              state_q       <= POINT;
            end else begin
              ball_x_q <= x_next;
              ball_y_q <= y_next;
              dir_y_q  <= dy_next;
            end
          end

          POINT: begin
            if (p1_scored_q ? (score_p1_q == WIN) : (score_p2_q == WIN)) begin
              state_q  <= GAME_OVER;
              winner_q <= p1_scored_q ? 2'b01 : 2'b10;
            end else begin
              // Serve toward the player who conceded.
              state_q     <= SERVE;
              serve_cnt_q <= '0;
              speed_q     <= SPD_INIT;
              hit_cnt_q   <= '0;
              dir_x_q     <= p1_scored_q;
              dir_y_q     <= ~dir_y_q;
            end
          end

          GAME_OVER: begin
            if (bus.start) begin
              score_p1_q  <= '0;
              score_p2_q  <= '0;
              winner_q    <= 2'b00;
              dir_x_q     <= 1'b0;
              state_q     <= SERVE;
              serve_cnt_q <= '0;
              speed_q     <= SPD_INIT;
              hit_cnt_q   <= '0;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ball_x      = ball_x_q;
  assign bus.ball_y      = ball_y_q;
  assign bus.dir_x       = dir_x_q;
  assign bus.dir_y       = dir_y_q;
  assign bus.speed       = speed_q;
  assign bus.score_p1    = score_p1_q;
  assign bus.score_p2    = score_p2_q;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.score_pulse = score_pulse_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// ---------------------------------------------------------------------------
// tb_pong_ball_engine
//
// Self-checking bench for pong_ball_engine. A behavioural model with plain
// integer arithmetic tracks the game; speed is derived from the number of
// hits in the current rally rather than from a counter. Paddles either
// follow the ball (with a random offset inside the hit window) or sit far
// from it; start is randomised where the engine must ignore it.
// ---------------------------------------------------------------------------
module tb_pong_ball_engine;

  localparam int H_RES          = 640;
  localparam int V_RES          = 480;
  localparam int BALL_SIZE      = 8;
  localparam int PADDLE_W       = 8;
  localparam int PADDLE_H       = 72;
  localparam int P1_X           = 32;
  localparam int P2_X           = 600;
  localparam int SPEED_INIT     = 2;
  localparam int SPEED_MAX      = 6;
  localparam int HITS_PER_LEVEL = 4;
  localparam int SERVE_DELAY    = 60;
  localparam int WIN_SCORE      = 11;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;
  localparam int TRACK = 0, MISS = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int m_state, m_bx, m_by, m_dx, m_dy, m_hits, m_scnt;
  int m_s1, m_s2, m_win, m_scorer;
  bit m_hit_p, m_score_p;

  function automatic int m_speed();
    int s;
    s = SPEED_INIT + m_hits / HITS_PER_LEVEL;
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  function automatic bit overlap(input int p);
    return (m_by + BALL_SIZE > p) && (m_by < p + PADDLE_H);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_bx = (H_RES - BALL_SIZE) / 2;
    m_by = (V_RES - BALL_SIZE) / 2;
    m_dx = 0; m_dy = 1;
    m_hits = 0; m_scnt = 0;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_scorer = 0;
    m_hit_p = 0; m_score_p = 0;
  endtask

  task automatic model_serve();
    m_state = S_SERVE;
    m_scnt  = 0;
    m_hits  = 0;
  endtask

  task automatic model_tick(input bit st);
    int spd, nx, ny, ndy, p1, p2;
    bit h1, h2;
`ifdef SPIN_EN
    int pad, off;
`endif
    p1 = int'(bus.paddle1_y);
    p2 = int'(bus.paddle2_y);
    m_hit_p = 0;
    m_score_p = 0;
    case (m_state)
      S_IDLE: if (st) model_serve();
      S_SERVE: begin
        if (m_scnt == SERVE_DELAY - 1) m_state = S_PLAY;
        else m_scnt++;
      end
      S_PLAY: begin
        spd = m_speed();
        ndy = m_dy;
        if (m_dy == 0) begin
          ny = m_by - spd;
          if (ny < 0) begin ny = 0; ndy = 1; end
        end else begin
          ny = m_by + spd;
          if (ny + BALL_SIZE > V_RES) begin ny = V_RES - BALL_SIZE; ndy = 0; end
        end
        h1 = (m_dx == 0) && (m_bx >= P1_X) && (m_bx - spd <= P1_X + PADDLE_W) && overlap(p1);
        h2 = (m_dx == 1) && (m_bx + BALL_SIZE <= P2_X + PADDLE_W) &&
             (m_bx + BALL_SIZE + spd >= P2_X) && overlap(p2);
        if (h1 || h2) begin
          m_hits++;
          m_hit_p = 1;
`ifdef SPIN_EN
          pad = h1 ? p1 : p2;
          off = m_by + BALL_SIZE / 2 - pad;
          if (off < PADDLE_H / 3) ndy = 0;
          else if (off >= (2 * PADDLE_H) / 3) ndy = 1;
`endif
          m_bx = h1 ? P1_X + PADDLE_W + 1 : P2_X - BALL_SIZE;
          m_dx = h1 ? 1 : 0;
          m_by = ny;
          m_dy = ndy;
        end else begin
          nx = (m_dx == 1) ? m_bx + spd : m_bx - spd;
          if (nx < 0 || nx + BALL_SIZE > H_RES) begin
            m_scorer = (nx < 0) ? 2 : 1;
            if (m_scorer == 1) m_s1++; else m_s2++;
            m_score_p = 1;
            m_state = S_POINT;
            m_bx = (H_RES - BALL_SIZE) / 2;
            m_by = (V_RES - BALL_SIZE) / 2;
          end else begin
            m_bx = nx;
            m_by = ny;
            m_dy = ndy;
          end
        end
      end
      S_POINT: begin
        if (((m_scorer == 1) ? m_s1 : m_s2) == WIN_SCORE) begin
          m_state = S_OVER;
          m_win = m_scorer;
        end else begin
          model_serve();
          m_dx = (m_scorer == 1) ? 1 : 0;
          m_dy = 1 - m_dy;
        end
      end
      S_OVER: begin
        if (st) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 0;
          model_serve();
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- observation formatting ----------------
  function automatic logic [44:0] dut_vec();
    return {bus.state, bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y, bus.speed,
            bus.score_p1, bus.score_p2, bus.winner, bus.hit_pulse, bus.score_pulse};
  endfunction

  function automatic logic [44:0] exp_vec();
    return {3'(m_state), 10'(m_bx), 10'(m_by), 1'(m_dx), 1'(m_dy), 4'(m_speed()),
            6'(m_s1), 6'(m_s2), 2'(m_win), m_hit_p, m_score_p};
  endfunction

  function automatic string fmt(input logic [44:0] v);
    return $sformatf("st=%0d x=%0d y=%0d dx=%0d dy=%0d spd=%0d s1=%0d s2=%0d win=%0d hit=%0d pt=%0d",
                     v[44:42], v[41:32], v[31:22], v[21], v[20], v[19:16],
                     v[15:10], v[9:4], v[3:2], v[1], v[0]);
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [9:0] paddle_for(input int mode);
    int p;
    if (mode == TRACK) begin
      p = m_by - int'($urandom_range(0, 60));
      if (p < 0) p = 0;
    end else begin
      p = (m_by < 240) ? 400 : 0;
    end
    return 10'(p);
  endfunction

  task automatic set_paddles(input int mode1, input int mode2);
    bus.paddle1_y = paddle_for(mode1);
    bus.paddle2_y = paddle_for(mode2);
  endtask

  // One frame: tick clk, then the model advances.
  task automatic tick(input bit st);
    bus.start = st;
    bus.refresh_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.refresh_tick = 1'b0;
    model_tick(st);
  endtask

  // One clk without refresh_tick: only the pulses may change (to 0).
  task automatic quiet_clk();
    @(posedge clk);
    #1;
    m_hit_p = 0;
    m_score_p = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_async: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    quiet_clk();
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_release: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
    else n_pass++;
    tick(1'b0);
    n_checks++;
    if (bus.state !== 3'd0 || dut_vec() !== exp_vec())
      $display("FAIL idle_no_start: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
    else n_pass++;
  endtask

  task automatic test_serve();
    tick(1'b1);
    n_checks++;
    if (bus.state !== 3'd1) $display("FAIL serve_entry: state got %0d want 1", bus.state);
    else n_pass++;
    for (int i = 0; i < SERVE_DELAY; i++) begin
      quiet_clk();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL serve_quiet: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL serve_tick %0d: got %s want %s", i, fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
    end
    n_checks++;
    if (bus.state !== 3'd2 || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236)
      $display("FAIL serve_to_play: state %0d x %0d y %0d want 2 316 236", bus.state, bus.ball_x, bus.ball_y);
    else n_pass++;
    quiet_clk();
    tick(1'b0);
    n_checks++;
    if (bus.ball_x !== 10'd314 || bus.ball_y !== 10'd238)
      $display("FAIL first_move: x %0d y %0d want 314 238", bus.ball_x, bus.ball_y);
    else n_pass++;
    quiet_clk();
    tick(1'b0);
    n_checks++;
    if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd240)
      $display("FAIL second_move: x %0d y %0d want 312 240", bus.ball_x, bus.ball_y);
    else n_pass++;
  endtask

  task automatic test_rally_speed();
    int budget = 0;
    int prev;
    while (m_hits < 18 && budget < 6000) begin
      quiet_clk();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL rally_quiet: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      set_paddles(TRACK, TRACK);
      prev = m_hits;
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL rally_tick: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      if (prev == 3 && m_hits == 4) begin
        n_checks++;
        if (bus.speed !== 4'd3 || bus.hit_pulse !== 1'b1)
          $display("FAIL fourth_hit: speed %0d hit %0d want 3 1", bus.speed, bus.hit_pulse);
        else n_pass++;
      end
      budget++;
    end
    n_checks++;
    if (m_hits < 18) $display("FAIL rally_timeout: hits %0d want 18", m_hits);
    else n_pass++;
    n_checks++;
    if (bus.speed !== 4'(SPEED_MAX)) $display("FAIL speed_saturate: got %0d want %0d", bus.speed, SPEED_MAX);
    else n_pass++;
  endtask

  task automatic test_point_p2();
    int budget = 0;
    int s2_before = m_s2;
    while (m_state != S_POINT && budget < 3000) begin
      quiet_clk();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL p2pt_quiet: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      set_paddles(MISS, TRACK);
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL p2pt_tick: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      budget++;
    end
    n_checks++;
    if (bus.state !== 3'd3 || bus.score_pulse !== 1'b1 || int'(bus.score_p2) != s2_before + 1)
      $display("FAIL p2_point: state %0d pulse %0d s2 %0d want 3 1 %0d",
               bus.state, bus.score_pulse, bus.score_p2, s2_before + 1);
    else n_pass++;
    quiet_clk();
    tick(1'b0);
    n_checks++;
    if (bus.state !== 3'd1 || bus.dir_x !== 1'b0 || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236)
      $display("FAIL p2_reserve: state %0d dx %0d x %0d y %0d want 1 0 316 236",
               bus.state, bus.dir_x, bus.ball_x, bus.ball_y);
    else n_pass++;
  endtask

  task automatic test_game_over();
    int budget = 0;
    while (m_state != S_OVER && budget < 8000) begin
      quiet_clk();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL game_quiet: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      set_paddles(TRACK, MISS);
      tick(1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL game_tick: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      budget++;
    end
    n_checks++;
    if (bus.state !== 3'd4 || bus.winner !== 2'b01 || bus.score_p1 !== 6'd11)
      $display("FAIL game_over: state %0d winner %0d s1 %0d want 4 1 11", bus.state, bus.winner, bus.score_p1);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      quiet_clk();
      set_paddles(TRACK, TRACK);
      tick(1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec() || bus.state !== 3'd4)
        $display("FAIL game_over_hold: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
    end
    quiet_clk();
    tick(1'b1);
    n_checks++;
    if (bus.state !== 3'd1 || bus.score_p1 !== 6'd0 || bus.score_p2 !== 6'd0 ||
        bus.winner !== 2'b00 || bus.dir_x !== 1'b0)
      $display("FAIL restart: got %s want state 1 scores 0 winner 0 dx 0", fmt(dut_vec()));
    else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    int budget = 0;
    int play_ticks = 0;
    while (play_ticks < 10 && budget < 200) begin
      quiet_clk();
      set_paddles(TRACK, TRACK);
      tick(1'b0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL prereset_tick: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
      else n_pass++;
      if (m_state == S_PLAY) play_ticks++;
      budget++;
    end
    n_checks++;
    if (play_ticks < 10) $display("FAIL prereset_timeout: play ticks %0d want 10", play_ticks);
    else n_pass++;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== exp_vec() || bus.state !== 3'd0)
      $display("FAIL reset_mid_play: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    quiet_clk();
    tick(1'b1);
    n_checks++;
    if (dut_vec() !== exp_vec() || bus.state !== 3'd1)
      $display("FAIL post_reset_start: got %s want %s", fmt(dut_vec()), fmt(exp_vec()));
    else n_pass++;
  endtask

  initial begin
    bus.refresh_tick = 1'b0;
    bus.start        = 1'b0;
    bus.paddle1_y    = '0;
    bus.paddle2_y    = '0;
    reset            = 1'b1;
    test_reset();
    test_serve();
    test_rally_speed();
    test_point_p2();
    test_game_over();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Parametrised ball engine for the pong game. Replaces fixed-geometry ball logic with configurable screen, paddle, speed and scoring. Adds a serve/play/point/game-over state machine, speed ramp on rally hits, clamped wall bounces, and wrap-free miss detection. Sits between the paddle controllers and the VGA renderer/score display; all motion advances on refresh_tick (one per frame).

Parameters:
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels
BALL_SIZE, 8, ball edge length in pixels
PADDLE_W, 8, paddle width
PADDLE_H, 72, paddle height
P1_X, 32, left paddle left edge x
P2_X, 600, right paddle left edge x
SPEED_INIT, 2, speed at each serve (pixels/tick per axis)
SPEED_MAX, 6, speed saturation value (must be <= 15)
HITS_PER_LEVEL, 4, paddle hits per speed increment
SERVE_DELAY, 60, ticks ball holds at centre before moving
WIN_SCORE, 11, score that ends the game (must be < 64)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
refresh_tick  input  1  one-clk pulse per frame; all updates gated by it
start  input  1  level; sampled only on refresh_tick
paddle1_y  input  10  left paddle top y
paddle2_y  input  10  right paddle top y
ball_x  output  10  ball left edge x
ball_y  output  10  ball top edge y
dir_x  output  1  1 = moving right
dir_y  output  1  1 = moving down
speed  output  4  current speed magnitude
score_p1  output  6  left player score
score_p2  output  6  right player score
winner  output  2  00 none, 01 P1, 10 P2
state  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4
hit_pulse  output  1  one-clk pulse on paddle hit
score_pulse  output  1  one-clk pulse on point scored

Behaviour:
- Reset (async): state IDLE; ball_x=(H_RES-BALL_SIZE)/2 (316), ball_y=(V_RES-BALL_SIZE)/2 (236); dir_x=0, dir_y=1; speed=SPEED_INIT; scores 0; winner 00; pulses 0; hit counter 0; serve counter 0.
- Nothing changes on a clk without refresh_tick, except pulses clear to 0 (pulses last exactly one clk).
- IDLE: ball centred; start=1 -> SERVE, serve counter cleared.
- SERVE: ball centred, not moving; serve counter increments per tick; at SERVE_DELAY-1 -> PLAY. speed=SPEED_INIT, hit counter=0 on entry.
- PLAY, per tick, axes independent. Direction and magnitude are unsigned; no two's-complement velocity.
- Y axis: dir_y=0 and ball_y < speed -> ball_y=0, dir_y=1. dir_y=1 and ball_y+BALL_SIZE+speed > V_RES -> ball_y=V_RES-BALL_SIZE, dir_y=0. Otherwise ball_y +/- speed.
- P1 hit: dir_x=0, ball_x >= P1_X, ball_x-speed <= P1_X+PADDLE_W, ball_y+BALL_SIZE > paddle1_y, ball_y < paddle1_y+PADDLE_H -> ball_x=P1_X+PADDLE_W+1, dir_x=1, hit_pulse.
- P2 hit (mirror): dir_x=1, ball_x+BALL_SIZE <= P2_X+PADDLE_W, ball_x+BALL_SIZE+speed >= P2_X, y overlap as above with paddle2_y -> ball_x=P2_X-BALL_SIZE, dir_x=0, hit_pulse.
- Each hit increments hit counter; on reaching HITS_PER_LEVEL counter clears and speed=min(speed+1, SPEED_MAX).
- Miss, checked only if no hit: dir_x=0 and ball_x < speed -> P2 point. dir_x=1 and ball_x+BALL_SIZE+speed > H_RES -> P1 point. Otherwise ball_x +/- speed.
- On point: scorer's score +1, score_pulse, -> POINT. Wall bounce in the same tick is discarded; ball re-centred.
- POINT (one tick): scorer's score == WIN_SCORE -> GAME_OVER, winner set. Else -> SERVE, dir_x toward the player who conceded, dir_y toggled.
- GAME_OVER: ball centred, frozen. start=1 -> scores 0, winner 00, dir_x=0, -> SERVE.
- start is ignored outside IDLE and GAME_OVER.
- Reset mid-rally returns to IDLE immediately; no score is awarded.

Optional Feature:
SPIN_EN. When defined, a paddle hit sets dir_y by contact zone. Ball centre (ball_y+BALL_SIZE/2) in top third of the paddle -> dir_y=0. Bottom third -> dir_y=1. Middle third -> dir_y unchanged. When undefined, a paddle hit never alters dir_y.

Test Plan:
- Reset, start=1 on one tick -> state SERVE; after 60 ticks state PLAY; ball_x 316->314->312, ball_y 236->238.
- Ball moving up at ball_y=1, speed 2 -> next ball_y=0, dir_y=1, no underflow.
- paddle1_y=200, ball at x=42, y=230, dir_x=0 -> ball_x=41, dir_x=1, hit_pulse one clk. After 4 such hits -> speed=3. Continued hits saturate at 6.
- paddle1_y=0, ball_x=1, ball_y=300, dir_x=0 -> score_p2 +1, score_pulse, POINT then SERVE with dir_x=0, ball centred.
- score_p1=10, right-edge miss -> score_p1=11, winner=01, GAME_OVER. Ticks without start hold; start=1 -> scores 0, SERVE.
- Reset asserted mid-PLAY between ticks -> outputs immediately at reset values, state IDLE. With SPIN_EN, a hit at paddle top third -> dir_y=0.
